// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller:
// state codes, ALU codes, opcode/funct values and mux encodings.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_ERR    = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1111;
    localparam logic [3:0] ALU_PASSA = 4'b1010;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_JR   = 6'b001000;

    localparam logic [1:0] ASRCB_B     = 2'b00;
    localparam logic [1:0] ASRCB_FOUR  = 2'b01;
    localparam logic [1:0] ASRCB_IMM   = 2'b10;
    localparam logic [1:0] ASRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU control decoder: picks alucontrol from the current state
// and op/funct, and flags unsupported R-type funct codes.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  state_t     state_i,
    output logic [3:0] alucontrol_o,
    output logic       illegal_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        illegal_o    = 1'b0;
        case (state_i)
            S_RTEXEC: begin
                case (funct_i)
                    F_ADD, F_ADDU: alucontrol_o = ALU_ADD;
                    F_SUB, F_SUBU: alucontrol_o = ALU_SUB;
                    F_AND:         alucontrol_o = ALU_AND;
                    F_OR:          alucontrol_o = ALU_OR;
                    F_SLT:         alucontrol_o = ALU_SLT;
                    F_SLTU:        alucontrol_o = ALU_SLTU;
                    default:       illegal_o    = 1'b1;
                endcase
            end
            S_BRANCH: alucontrol_o = ALU_SUB;
            S_IEXEC: begin
                case (op_i)
                    OP_ORI:   alucontrol_o = ALU_OR;
                    OP_SLTI:  alucontrol_o = ALU_SLT;
                    OP_SLTIU: alucontrol_o = ALU_SLTU;
                    default:  alucontrol_o = ALU_ADD;
                endcase
            end
            S_JR:    alucontrol_o = ALU_PASSA;
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH..WB over a shared
// memory port, stalls on memready and traps illegal/timeout cases.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       signext,
    output logic       shiftl16,
    output logic [3:0] alucontrol,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       jal,
    output logic       err,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q;
    logic       lw_q, lw_d;
    logic       illegal_funct;
    logic       stall;
    logic       timeout;
    logic       en;

    mips_mc_aludec u_aludec (
        .op_i         (op),
        .funct_i      (funct),
        .state_i      (state_q),
        .alucontrol_o (alucontrol),
        .illegal_o    (illegal_funct)
    );

    assign stall   = is_mem_state(state_q) && !memready;
    assign timeout = stall && (cnt_q == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        lw_d    = lw_q;
        case (state_q)
            S_FETCH:  if (memready) state_d = S_DECODE;
            S_DECODE: begin
                // LW/SW choice is latched here so MEMADR never reads op
                lw_d = (op == OP_LW);
                case (op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = (funct == F_JR) ? S_JR : S_RTEXEC;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ORI,
                    OP_SLTI, OP_SLTIU, OP_LUI:
                                     state_d = S_IEXEC;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    default:         state_d = S_ERR;
                endcase
            end
            S_MEMADR: state_d = lw_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (memready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (memready) state_d = S_FETCH;
            S_RTEXEC: state_d = illegal_funct ? S_ERR : S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            S_JR:     state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
        if (timeout) state_d = S_ERR;

        if (state_d != state_q)
            cnt_d = '0;
        else if (stall)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            lw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | (state_d == S_ERR);
            lw_q    <= lw_d;
        end
    end

    // Holding reset low masks every enable, aborting any access
    assign en = reset;

    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        pcsrc    = PCSRC_ALU;
        alusrca  = 1'b0;
        alusrcb  = ASRCB_B;
        signext  = 1'b0;
        shiftl16 = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        jal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = en;
                alusrcb = ASRCB_FOUR;
                irwrite = en & memready;
                pcen    = en & memready;
            end
            S_DECODE: alusrcb = ASRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ASRCB_IMM;
                signext = 1'b1;
            end
            S_MEMRD: begin
                memread = en;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = en;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = en;
                iord     = 1'b1;
            end
            S_RTEXEC: alusrca = 1'b1;
            S_ALUWB: begin
                regwrite = en;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = PCSRC_ALUOUT;
                pcen    = en & (op[0] ? ~zero : zero);
            end
            S_IEXEC: begin
                alusrca  = 1'b1;
                alusrcb  = ASRCB_IMM;
                signext  = (op != OP_ORI) && (op != OP_LUI);
                shiftl16 = (op == OP_LUI);
            end
            S_IWB: regwrite = en;
            S_JUMP: begin
                pcsrc = PCSRC_JUMP;
                pcen  = en;
            end
            S_JAL: begin
                pcsrc    = PCSRC_JUMP;
                pcen     = en;
                regwrite = en;
                jal      = 1'b1;
            end
            S_JR: begin
                alusrca = 1'b1;
                pcen    = en;
            end
            default: ;
        endcase
    end

    assign err   = err_q;
    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed vector bench for the multicycle MIPS controller.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;
    logic       memread, memwrite, iord, irwrite, pcen;
    logic [1:0] pcsrc, alusrcb;
    logic       alusrca, signext, shiftl16;
    logic [3:0] alucontrol, state;
    logic       regdst, memtoreg, regwrite, jal, err;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .memready(memready),
        .memread(memread), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .signext(signext),
        .shiftl16(shiftl16), .alucontrol(alucontrol),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .jal(jal), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ORI = 6'b001101;
    localparam logic [5:0] SLTIU = 6'b001011, LUI = 6'b001111;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] BAD = 6'b111111;

    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;
    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001;
    localparam logic [3:0] SLT = 4'b0111, SLTU = 4'b1111;
    localparam logic [3:0] PASSA = 4'b1010;

    // {iord, alusrca, alusrcb[1:0], regdst, memtoreg, jal, signext, shiftl16}
    localparam logic [8:0] M_F   = 9'b000100000;
    localparam logic [8:0] M_D   = 9'b001100000;
    localparam logic [8:0] M_MA  = 9'b011000010;
    localparam logic [8:0] M_IO  = 9'b100000000;
    localparam logic [8:0] M_MWB = 9'b000001000;
    localparam logic [8:0] M_A   = 9'b010000000;
    localparam logic [8:0] M_AWB = 9'b000010000;
    localparam logic [8:0] M_JAL = 9'b000000100;
    localparam logic [8:0] M_IZ  = 9'b011000000;
    localparam logic [8:0] M_IS  = 9'b011000010;
    localparam logic [8:0] M_LUI = 9'b011000001;
    localparam logic [8:0] M_0   = 9'b000000000;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        z;
        logic        mr;
        logic [24:0] exp;
    } vec_t;

    vec_t vq[$];

    // en5 = {memread, memwrite, irwrite, pcen, regwrite}
    task automatic r(input logic rst, input logic [5:0] o,
                     input logic [5:0] f, input logic z,
                     input logic mr, input logic [3:0] st,
                     input logic [4:0] en5, input logic [1:0] ps,
                     input logic [3:0] alu, input logic e,
                     input logic [8:0] mx);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.z = z; v.mr = mr;
        v.exp = {st, en5, ps, alu, e, mx};
        vq.push_back(v);
    endtask

    function automatic logic [24:0] act();
        return {state, memread, memwrite, irwrite, pcen, regwrite,
                pcsrc, alucontrol, err, iord, alusrca, alusrcb,
                regdst, memtoreg, jal, signext, shiftl16};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic drive(input logic rst, input logic [5:0] o,
                         input logic [5:0] f, input logic mr);
        @(negedge clk);
        reset = rst; op = o; funct = f; memready = mr; zero = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0; memready = 1'b1;
        repeat (2) @(posedge clk);

        r(0, R, 0, 0, 1, 0, 5'b00000, 2'b00, ADD, 0, M_F);
        // LW
        r(1, LW, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, LW, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, LW, 0, 0, 1, 2, 5'b00000, 2'b00, ADD, 0, M_MA);
        r(1, LW, 0, 0, 1, 3, 5'b10000, 2'b00, ADD, 0, M_IO);
        r(1, LW, 0, 0, 1, 4, 5'b00001, 2'b00, ADD, 0, M_MWB);
        // R-type sub, slt, and
        r(1, R, 6'b100010, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, R, 6'b100010, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, R, 6'b100010, 0, 1, 6, 5'b00000, 2'b00, SUB, 0, M_A);
        r(1, R, 6'b100010, 0, 1, 7, 5'b00001, 2'b00, ADD, 0, M_AWB);
        r(1, R, 6'b101010, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, R, 6'b101010, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, R, 6'b101010, 0, 1, 6, 5'b00000, 2'b00, SLT, 0, M_A);
        r(1, R, 6'b101010, 0, 1, 7, 5'b00001, 2'b00, ADD, 0, M_AWB);
        r(1, R, 6'b100100, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, R, 6'b100100, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, R, 6'b100100, 0, 1, 6, 5'b00000, 2'b00, AND_, 0, M_A);
        r(1, R, 6'b100100, 0, 1, 7, 5'b00001, 2'b00, ADD, 0, M_AWB);
        // BEQ taken, BNE not taken, BNE taken
        r(1, BEQ, 0, 1, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, BEQ, 0, 1, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, BEQ, 0, 1, 1, 8, 5'b00010, 2'b01, SUB, 0, M_A);
        r(1, BNE, 0, 1, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, BNE, 0, 1, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, BNE, 0, 1, 1, 8, 5'b00000, 2'b01, SUB, 0, M_A);
        r(1, BNE, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, BNE, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, BNE, 0, 0, 1, 8, 5'b00010, 2'b01, SUB, 0, M_A);
        // ORI, SLTIU, LUI
        r(1, ORI, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, ORI, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, ORI, 0, 0, 1, 9, 5'b00000, 2'b00, OR_, 0, M_IZ);
        r(1, ORI, 0, 0, 1, 10, 5'b00001, 2'b00, ADD, 0, M_0);
        r(1, SLTIU, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, SLTIU, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, SLTIU, 0, 0, 1, 9, 5'b00000, 2'b00, SLTU, 0, M_IS);
        r(1, SLTIU, 0, 0, 1, 10, 5'b00001, 2'b00, ADD, 0, M_0);
        r(1, LUI, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, LUI, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, LUI, 0, 0, 1, 9, 5'b00000, 2'b00, ADD, 0, M_LUI);
        r(1, LUI, 0, 0, 1, 10, 5'b00001, 2'b00, ADD, 0, M_0);
        // SW
        r(1, SW, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, SW, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, SW, 0, 0, 1, 2, 5'b00000, 2'b00, ADD, 0, M_MA);
        r(1, SW, 0, 0, 1, 5, 5'b01000, 2'b00, ADD, 0, M_IO);
        // J, JAL, JR
        r(1, J, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, J, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, J, 0, 0, 1, 11, 5'b00010, 2'b10, ADD, 0, M_0);
        r(1, JAL, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, JAL, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, JAL, 0, 0, 1, 12, 5'b00011, 2'b10, ADD, 0, M_JAL);
        r(1, R, 6'b001000, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, R, 6'b001000, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, R, 6'b001000, 0, 1, 13, 5'b00010, 2'b00, PASSA, 0, M_A);
        // illegal opcode, sticky ERR, reset out
        r(1, BAD, 0, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, BAD, 0, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, BAD, 0, 0, 0, 15, 5'b00000, 2'b00, ADD, 1, M_0);
        r(1, BAD, 0, 0, 1, 15, 5'b00000, 2'b00, ADD, 1, M_0);
        r(1, BAD, 0, 0, 0, 15, 5'b00000, 2'b00, ADD, 1, M_0);
        r(0, BAD, 0, 0, 1, 15, 5'b00000, 2'b00, ADD, 1, M_0);
        r(1, R, 6'b000000, 0, 1, 0, 5'b10110, 2'b00, ADD, 0, M_F);
        r(1, R, 6'b000000, 0, 1, 1, 5'b00000, 2'b00, ADD, 0, M_D);
        r(1, R, 6'b000000, 0, 1, 6, 5'b00000, 2'b00, ADD, 0, M_A);
        r(1, R, 6'b000000, 0, 1, 15, 5'b00000, 2'b00, ADD, 1, M_0);
        r(0, R, 6'b000000, 0, 1, 15, 5'b00000, 2'b00, ADD, 1, M_0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; op = vq[i].op; funct = vq[i].funct;
            zero = vq[i].z; memready = vq[i].mr;
            #1;
            total++;
            if (act() !== vq[i].exp) begin
                bad++;
                $display("FAIL vec%0d outs got=%b want=%b",
                         i, act(), vq[i].exp);
            end
        end

        // fetch stall: 3 low cycles then one accept
        for (int i = 0; i < 3; i++) begin
            drive(1, J, 0, 0);
            chk("stall_state", 32'(state), 32'd0);
            chk("stall_ir_pc", {30'd0, irwrite, pcen}, 32'd0);
        end
        drive(1, J, 0, 1);
        chk("fetch_accept", {30'd0, irwrite, pcen}, 32'd3);
        drive(1, J, 0, 1);
        chk("after_fetch_state", 32'(state), 32'd1);
        chk("after_fetch_ir", {30'd0, irwrite, pcen}, 32'd0);
        drive(1, J, 0, 1);
        chk("jump_state", 32'(state), 32'd11);

        // MEMRD timeout
        drive(1, LW, 0, 1);
        chk("to_fetch", 32'(state), 32'd0);
        drive(1, LW, 0, 1);
        drive(1, LW, 0, 1);
        chk("to_memadr", 32'(state), 32'd2);
        for (int i = 0; i < 16; i++) begin
            drive(1, LW, 0, 0);
            chk($sformatf("memrd_wait%0d", i), 32'(state), 32'd3);
        end
        drive(1, LW, 0, 0);
        chk("timeout_state", 32'(state), 32'd15);
        chk("timeout_err", 32'(err), 32'd1);
        drive(1, LW, 0, 1);
        chk("err_hold", {27'd0, state, err}, {27'd0, 4'd15, 1'b1});
        drive(0, LW, 0, 1);
        drive(1, SW, 0, 1);
        chk("reset_exit", {27'd0, state, err}, 32'd0);

        // reset while a store is pending
        drive(1, SW, 0, 1);
        drive(1, SW, 0, 1);
        drive(1, SW, 0, 0);
        chk("memwr_state", 32'(state), 32'd5);
        chk("memwr_req", 32'(memwrite), 32'd1);
        drive(0, SW, 0, 1);
        chk("memwr_rst_en", {27'd0, memread, memwrite, irwrite,
                             pcen, regwrite}, 32'd0);
        drive(1, SW, 0, 1);
        chk("memwr_rst_state", 32'(state), 32'd0);
        chk("memwr_rst_wr", 32'(memwrite), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
